ysyx_22040127_fetch_unit: RTL and testbench

//  Parametrised instruction-fetch front end for the ysyx_22040127 core, replacing the combinational
//  per-cycle pmem_read fetch. Issues aligned MEM_W-bit reads over a valid/ready request port and

---
 rtl/ysyx_22040127_pkg.sv | 15 +
 rtl/ysyx_22040127_inst_queue.sv | 95 +++++++++
 rtl/ysyx_22040127_fetch_unit.sv | 142 ++++++++++++++
 tb/tb_ysyx_22040127_fetch_unit.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22040127_pkg.sv
// rtl/ysyx_22040127_pkg.sv - shared types and constants for the instruction fetch front end
package ysyx_22040127_pkg;

  localparam int          INST_W           = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

  typedef enum logic [2:0] {
    FS_IDLE,
    FS_REQ,
    FS_WAIT,
    FS_REQ_STALE,
    FS_WAIT_STALE
  } fetch_state_e;

endpackage

// File: rtl/ysyx_22040127_inst_queue.sv
// rtl/ysyx_22040127_inst_queue.sv - {inst, pc} FIFO with 0/1/2-wide push, 1-wide pop and flush
module ysyx_22040127_inst_queue
  import ysyx_22040127_pkg::*;
#(
  parameter int PC_W  = 32,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [1:0]        push_cnt,
  input  logic [INST_W-1:0] push_inst0,
  input  logic [PC_W-1:0]   push_pc0,
  input  logic [INST_W-1:0] push_inst1,
  input  logic [PC_W-1:0]   push_pc1,
  input  logic              pop,
  output logic [CNT_W-1:0]  count,
  output logic [INST_W-1:0] head_inst,
  output logic [PC_W-1:0]   head_pc
);

  logic [INST_W-1:0] inst_q [DEPTH];
  logic [INST_W-1:0] inst_d [DEPTH];
  logic [PC_W-1:0]   pc_q   [DEPTH];
  logic [PC_W-1:0]   pc_d   [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              pop_en;

  // Pointer wrap handles non power-of-two depths.
  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input logic [1:0] n);
    logic [PTR_W:0] s;
    s = {1'b0, p} + (PTR_W+1)'(n);
    if (s >= (PTR_W+1)'(DEPTH)) s = s - (PTR_W+1)'(DEPTH);
    return s[PTR_W-1:0];
  endfunction

  assign pop_en = pop && (count_q != '0);

  always_comb begin
    inst_d  = inst_q;
    pc_d    = pc_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_cnt != 2'd0) begin
        inst_d[tail_q] = push_inst0;
        pc_d[tail_q]   = push_pc0;
      end
      if (push_cnt == 2'd2) begin
        inst_d[ptr_add(tail_q, 2'd1)] = push_inst1;
        pc_d[ptr_add(tail_q, 2'd1)]   = push_pc1;
      end
      tail_d  = ptr_add(tail_q, push_cnt);
      head_d  = pop_en ? ptr_add(head_q, 2'd1) : head_q;
      count_d = count_q + CNT_W'(push_cnt) - CNT_W'(pop_en);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        inst_q[i] <= '0;
        pc_q[i]   <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      inst_q  <= inst_d;
      pc_q    <= pc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      a_no_overflow: assert (int'(count_q) + int'(push_cnt) - int'(pop_en) <= DEPTH);
    end
  end

  assign count     = count_q;
  assign head_inst = inst_q[head_q];
  assign head_pc   = pc_q[head_q];

endmodule

// File: rtl/ysyx_22040127_fetch_unit.sv
// rtl/ysyx_22040127_fetch_unit.sv - beat fetch FSM with redirect handling feeding the instruction queue
module ysyx_22040127_fetch_unit
  import ysyx_22040127_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter int              MEM_W    = 64,
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [PC_W-1:0]   mem_req_addr,
  input  logic              mem_resp_valid,
  input  logic [MEM_W-1:0]  mem_resp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [PC_W-1:0]   inst_pc
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  if (DEPTH < 2) begin : g_bad_depth
    $error("ysyx_22040127_fetch_unit: DEPTH must be >= 2");
  end
  if (MEM_W != 64) begin : g_bad_mem_w
    $error("ysyx_22040127_fetch_unit: MEM_W must be 64");
  end

  fetch_state_e      state_q, state_d;
  logic [PC_W-1:0]   fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0]   req_addr_q, req_addr_d;
  logic              mem_req_valid_q, mem_req_valid_d;

  logic [CNT_W-1:0]  q_count;
  logic [1:0]        push_cnt;
  logic [INST_W-1:0] push_inst0, push_inst1;
  logic [PC_W-1:0]   push_pc0, push_pc1;
  logic              credit_ok, req_fire, pop;
  logic [PC_W-1:0]   redirect_target;
  logic              unused_redirect_lo;

  assign redirect_target    = {redirect_pc[PC_W-1:2], 2'b00};
  assign unused_redirect_lo = ^redirect_pc[1:0];
  assign credit_ok          = int'(q_count) <= DEPTH - 2;
  assign req_fire           = mem_req_valid_q && mem_req_ready;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    push_cnt   = 2'd0;
    push_inst0 = mem_resp_data[31:0];
    push_pc0   = fetch_pc_q;
    push_inst1 = mem_resp_data[63:32];
    push_pc1   = fetch_pc_q + PC_W'(4);
    unique case (state_q)
      FS_IDLE: begin
        if (!redirect_valid && credit_ok) begin
          state_d    = FS_REQ;
          req_addr_d = {fetch_pc_q[PC_W-1:3], 3'b000};
        end
      end
      FS_REQ: begin
        if (req_fire)            state_d = redirect_valid ? FS_WAIT_STALE : FS_WAIT;
        else if (redirect_valid) state_d = FS_REQ_STALE;
      end
      FS_WAIT: begin
        if (mem_resp_valid) begin
          state_d = FS_IDLE;
          if (!redirect_valid) begin
            // A word-aligned fetch_pc in the upper half only uses the hi slot.
            if (fetch_pc_q[2]) begin
              push_cnt   = 2'd1;
              push_inst0 = mem_resp_data[63:32];
              fetch_pc_d = fetch_pc_q + PC_W'(4);
            end else begin
              push_cnt   = 2'd2;
              fetch_pc_d = fetch_pc_q + PC_W'(8);
            end
          end
        end else if (redirect_valid) begin
          state_d = FS_WAIT_STALE;
        end
      end
      FS_REQ_STALE:  if (req_fire)       state_d = FS_WAIT_STALE;
      FS_WAIT_STALE: if (mem_resp_valid) state_d = FS_IDLE;
      default:                           state_d = FS_IDLE;
    endcase
    if (redirect_valid) fetch_pc_d = redirect_target;
    mem_req_valid_d = (state_d == FS_REQ) || (state_d == FS_REQ_STALE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= FS_IDLE;
      fetch_pc_q      <= RESET_PC;
      req_addr_q      <= '0;
      mem_req_valid_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      fetch_pc_q      <= fetch_pc_d;
      req_addr_q      <= req_addr_d;
      mem_req_valid_q <= mem_req_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      a_resp_when_waiting: assert (!mem_resp_valid || state_q == FS_WAIT || state_q == FS_WAIT_STALE);
    end
  end

  assign pop = inst_valid && inst_ready;

  ysyx_22040127_inst_queue #(
    .PC_W  (PC_W),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect_valid),
    .push_cnt   (push_cnt),
    .push_inst0 (push_inst0),
    .push_pc0   (push_pc0),
    .push_inst1 (push_inst1),
    .push_pc1   (push_pc1),
    .pop        (pop),
    .count      (q_count),
    .head_inst  (inst),
    .head_pc    (inst_pc)
  );

  assign inst_valid    = q_count != '0;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_addr  = req_addr_q;

endmodule

// File: tb/tb_ysyx_22040127_fetch_unit.sv
// tb/tb_ysyx_22040127_fetch_unit.sv - scoreboard bench for the fetch unit with a latency-programmable memory
module tb_ysyx_22040127_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b1;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid = 1'b0;
  logic [63:0] mem_resp_data = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  int total = 0;
  int bad   = 0;
  int lat   = 1;
  logic [31:0] exp_q[$];
  logic [31:0] acc_q[$];

  always #5 clk = ~clk;

  ysyx_22040127_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc)
  );

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'hC3A5_0F1E;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory: one outstanding read, response lat cycles after accept.
  initial begin
    int          cnt;
    logic        pend;
    logic [31:0] paddr;
    pend = 1'b0; cnt = 0; paddr = '0;
    forever begin
      @(negedge clk);
      mem_resp_valid = 1'b0;
      if (rst) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          cnt--;
          if (cnt == 0) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = {word_at(paddr + 32'd4), word_at(paddr)};
            pend = 1'b0;
          end
        end
        if (mem_req_valid && mem_req_ready) begin
          pend  = 1'b1;
          cnt   = lat;
          paddr = mem_req_addr;
          acc_q.push_back(mem_req_addr);
        end
      end
    end
  end

  // Monitor: every delivered instruction is popped from the scoreboard.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!rst && inst_valid && inst_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL mon_unexpected: got pc %h expected no instruction", inst_pc);
        end else begin
          e = exp_q.pop_front();
          check("mon_pc", inst_pc, e);
          check("mon_inst", inst, word_at(e));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic redirect(input logic [31:0] pc);
    redirect_pc    = pc;
    redirect_valid = 1'b1;
    tick();
    redirect_valid = 1'b0;
  endtask

  task automatic expect_stream(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  task automatic wait_drained(input string name);
    int c = 0;
    while (exp_q.size() != 0 && c < 2000) begin
      tick();
      c++;
    end
    check({name, "_drain_left"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic wait_acc(input int n, input string name);
    int c = 0;
    while (acc_q.size() < n && c < 500) begin
      tick();
      c++;
    end
    check({name, "_acc_count"}, 32'(acc_q.size() >= n), 32'd1);
  endtask

  task automatic settle();
    inst_ready = 1'b0;
    repeat (30) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) tick();
    check("rst_req_valid", 32'(mem_req_valid), 32'd0);
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_inst_pc", inst_pc, 32'd0);
    rst = 1'b0;

    expect_stream(32'h8000_0000, 10);
    wait_acc(1, "boot");
    if (acc_q.size() >= 1) check("boot_first_addr", acc_q[0], 32'h8000_0000);
    inst_ready = 1'b1;
    wait_drained("boot");
    settle();

    acc_q.delete();
    redirect(32'h8000_0014);
    wait_acc(1, "idle_redir");
    if (acc_q.size() >= 1) check("idle_redir_addr", acc_q[0], 32'h8000_0010);
    expect_stream(32'h8000_0014, 6);
    inst_ready = 1'b1;
    wait_drained("idle_redir");
    settle();

    lat = 5;
    settle();
    acc_q.delete();
    redirect(32'h8000_0100);
    wait_acc(1, "wait_redir_a");
    tick();
    tick();
    redirect(32'h8000_0204);
    wait_acc(2, "wait_redir_b");
    if (acc_q.size() >= 2) begin
      check("wait_redir_old_addr", acc_q[0], 32'h8000_0100);
      check("wait_redir_new_addr", acc_q[1], 32'h8000_0200);
    end
    expect_stream(32'h8000_0204, 5);
    inst_ready = 1'b1;
    wait_drained("wait_redir");
    settle();

    lat = 1;
    settle();
    mem_req_ready = 1'b0;
    acc_q.delete();
    redirect(32'h8000_0300);
    repeat (3) tick();
    check("stall_req_valid", 32'(mem_req_valid), 32'd1);
    check("stall_addr", mem_req_addr, 32'h8000_0300);
    redirect(32'h8000_0400);
    tick();
    check("stall_addr_held", mem_req_addr, 32'h8000_0300);
    redirect(32'h8000_050F);
    mem_req_ready = 1'b1;
    wait_acc(2, "stall");
    if (acc_q.size() >= 2) begin
      check("stall_old_addr", acc_q[0], 32'h8000_0300);
      check("stall_new_addr", acc_q[1], 32'h8000_0508);
    end
    expect_stream(32'h8000_050C, 5);
    inst_ready = 1'b1;
    wait_drained("stall");
    settle();

    acc_q.delete();
    redirect(32'h8000_1000);
    repeat (40) tick();
    check("bp_beats", 32'(acc_q.size()), 32'd2);
    check("bp_req_idle", 32'(mem_req_valid), 32'd0);
    check("bp_inst_valid", 32'(inst_valid), 32'd1);
    check("bp_head_pc", inst_pc, 32'h8000_1000);
    expect_stream(32'h8000_1000, 12);
    inst_ready = 1'b1;
    wait_drained("bp");
    settle();

    acc_q.delete();
    redirect(32'hFFFF_FFF8);
    expect_stream(32'hFFFF_FFF8, 4);
    inst_ready = 1'b1;
    wait_drained("wrap");
    wait_acc(2, "wrap");
    if (acc_q.size() >= 2) begin
      check("wrap_addr0", acc_q[0], 32'hFFFF_FFF8);
      check("wrap_addr1", acc_q[1], 32'h0000_0000);
    end
    inst_ready = 1'b0;
    repeat (5) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
